// File: rtl/panel_key_event_ctrl.sv
// Front-panel key and rotary-encoder event controller.
// Raw keys are synchronized, debounced on a slow sample tick, turned into
// press/release events and queued in an 8-deep show-ahead FIFO. Two
// quadrature encoders are decoded every clock into signed step counts.

// Per-key debouncer: flips the stable level after DB_SAMPLES consecutive
// differing sample ticks.
module panel_key_debounce #(
  parameter logic [2:0] DB_SAMPLES = 3'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic state,
  output logic flip
);

  logic [2:0] cnt;
  logic       differ;

  // A flip is due when this tick would bring the counter to DB_SAMPLES.
  always_comb begin
    differ = level ^ state;
    flip   = tick && differ && ((cnt + 3'd1) == DB_SAMPLES);
  end

  // Counter and stable level; counter clears on agreement or on a flip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b1;
    end else if (tick) begin
      if (!differ || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
      if (flip) begin
        state <= ~state;
      end
    end
  end

endmodule

// Quadrature decoder with its own 2-flop synchronizer.
module panel_quad_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  output logic [7:0] count
);

  logic [1:0] meta;
  logic [1:0] sync;
  logic [1:0] prev;
  logic [1:0] delta;
  logic       inc;
  logic       dec;

  // Gray {A,B} to position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Position difference mod 4: +1 forward, -1 reverse, 0 or 2 ignored.
  always_comb begin
    delta = gray_pos(sync) - gray_pos(prev);
    inc   = (delta == 2'd1);
    dec   = (delta == 2'd3);
  end

  // Synchronizer, previous-state register and wrapping step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= '1;
      sync  <= '1;
      prev  <= '1;
      count <= '0;
    end else begin
      meta <= {a, b};
      sync <= meta;
      prev <= sync;
      if (inc) begin
        count <= count + 8'd1;
      end else if (dec) begin
        count <= count - 8'd1;
      end
    end
  end

endmodule

// 8-deep show-ahead event FIFO; head reads as zero while empty.
module panel_event_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic       valid,
  output logic       full,
  output logic [7:0] head
);

  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       pop;

  // Status flags and gated head; pops while empty are ignored.
  always_comb begin
    valid = (count != 4'd0);
    full  = (count == 4'd8);
    pop   = pop_req && valid;
    head  = valid ? mem[rd_ptr] : '0;
  end

  // Storage needs no reset: it is only visible through the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module panel_key_event_ctrl #(
  parameter logic [15:0] TICK_DIV   = 16'd50000,
  parameter logic [2:0]  DB_SAMPLES = 3'd4
) (
  input  logic        PLD_MCLK,
  input  logic        EPL_RESETN,
  input  logic [12:0] KEY_IN,
  input  logic        ENC0_A,
  input  logic        ENC0_B,
  input  logic        ENC1_A,
  input  logic        ENC1_B,
  input  logic        EVT_READ,
  input  logic        LOST_CLR,
  output logic [12:0] KEY_STATE,
  output logic        EVT_VALID,
  output logic [7:0]  EVT_DATA,
  output logic [7:0]  ENC0_COUNT,
  output logic [7:0]  ENC1_COUNT,
  output logic        IRQ_N,
  output logic        LOST
);

  logic [12:0] key_meta;
  logic [12:0] key_sync;
  logic [15:0] presc;
  logic        tick;
  logic [12:0] flip;
  logic [12:0] pending;
  logic [12:0] pol;
  logic [12:0] grant;
  logic        grant_any;
  logic [3:0]  grant_idx;
  logic [12:0] overwrite;
  logic [7:0]  push_data;
  logic        fifo_full;

  // Two-flop synchronizer for the raw keys.
  always_ff @(posedge PLD_MCLK) begin
    if (!EPL_RESETN) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= KEY_IN;
      key_sync <= key_meta;
    end
  end

  // Sample tick is high during the last prescaler count.
  always_comb begin
    tick = (presc == (TICK_DIV - 16'd1));
  end

  // Prescaler counting 0..TICK_DIV-1.
  always_ff @(posedge PLD_MCLK) begin
    if (!EPL_RESETN) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  for (genvar g = 0; g < 13; g++) begin : g_key
    panel_key_debounce #(
      .DB_SAMPLES(DB_SAMPLES)
    ) u_db (
      .clk   (PLD_MCLK),
      .rst_n (EPL_RESETN),
      .tick  (tick),
      .level (key_sync[g]),
      .state (KEY_STATE[g]),
      .flip  (flip[g])
    );
  end

  // Fixed-priority grant of the lowest pending key while the FIFO has room.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < 13; i++) begin
        if (pending[i] && !grant_any) begin
          grant[i]  = 1'b1;
          grant_any = 1'b1;
          grant_idx = 4'(i);
        end
      end
    end
    // A key granted this cycle may flip again without losing anything:
    // the old edge is pushed now and the new one becomes pending.
    overwrite = flip & pending & ~grant;
    push_data = {pol[grant_idx], 3'b000, grant_idx};
  end

  // Pending edges and their polarity; pol is 1 when the key went to 0.
  always_ff @(posedge PLD_MCLK) begin
    if (!EPL_RESETN) begin
      pending <= '0;
      pol     <= '0;
    end else begin
      pending <= (pending & ~grant) | flip;
      pol     <= (pol & ~flip) | (flip & KEY_STATE);
    end
  end

  // Sticky lost flag; a same-cycle overwrite wins over the clear.
  always_ff @(posedge PLD_MCLK) begin
    if (!EPL_RESETN) begin
      LOST <= 1'b0;
    end else if (|overwrite) begin
      LOST <= 1'b1;
    end else if (LOST_CLR) begin
      LOST <= 1'b0;
    end
  end

  panel_event_fifo u_fifo (
    .clk       (PLD_MCLK),
    .rst_n     (EPL_RESETN),
    .push      (grant_any),
    .push_data (push_data),
    .pop_req   (EVT_READ),
    .valid     (EVT_VALID),
    .full      (fifo_full),
    .head      (EVT_DATA)
  );

  // Interrupt is asserted low while any event is queued.
  always_comb begin
    IRQ_N = ~EVT_VALID;
  end

  panel_quad_decoder u_enc0 (
    .clk   (PLD_MCLK),
    .rst_n (EPL_RESETN),
    .a     (ENC0_A),
    .b     (ENC0_B),
    .count (ENC0_COUNT)
  );

  panel_quad_decoder u_enc1 (
    .clk   (PLD_MCLK),
    .rst_n (EPL_RESETN),
    .a     (ENC1_A),
    .b     (ENC1_B),
    .count (ENC1_COUNT)
  );

endmodule

// File: doc/panel_key_event_ctrl.md
PANEL_KEY_EVENT_CTRL -- requirements
Module: panel_key_event_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 16'd50000, PLD_MCLK cycles per debounce sample tick (legal range 2..65535).
REQ-002 Parameter DB_SAMPLES, default 3'd4, consecutive differing ticks needed to flip a debounced key (legal range 1..7).
REQ-003 PLD_MCLK  in  1  the only clock; all logic is on its rising edge.
REQ-004 EPL_RESETN  in  1  reset, synchronous, active-low.
REQ-005 KEY_IN  in  13  raw active-low keys; bit order UP, DN, LFT, RHT, ENT, ESC, ST[0..5], RINk.
REQ-006 ENC0_A, ENC0_B  in  1 each  raw quadrature inputs of encoder 0 (RIN1/RIN2).
REQ-007 ENC1_A, ENC1_B  in  1 each  raw quadrature inputs of encoder 1 (REX1/REX2).
REQ-008 EVT_READ  in  1  pop request for the event FIFO head.
REQ-009 LOST_CLR  in  1  clears LOST.
REQ-010 KEY_STATE  out  13  debounced key levels, active-low.
REQ-011 EVT_VALID  out  1  FIFO not empty.
REQ-012 EVT_DATA  out  8  FIFO head (show-ahead); bit7 = 1 press / 0 release, bits6:4 = 000, bits3:0 = key index.
REQ-013 ENC0_COUNT, ENC1_COUNT  out  8 each  signed two's-complement step counts.
REQ-014 IRQ_N  out  1  low while EVT_VALID = 1.
REQ-015 LOST  out  1  sticky flag: an edge was overwritten before it was posted.

Function
REQ-016 All raw inputs SHALL pass through a 2-flop synchronizer before use.
REQ-017 A prescaler SHALL pulse tick for one cycle every TICK_DIV cycles, counting 0..TICK_DIV-1 and then wrapping to 0.
REQ-018 Per key, on each tick: if the synchronized level differs from KEY_STATE, a 3-bit counter SHALL increment; otherwise it SHALL clear; on reaching DB_SAMPLES, KEY_STATE SHALL flip and the counter SHALL clear.
REQ-019 A KEY_STATE flip SHALL set pending[i] and record pol[i] (1 = flipped to 0, i.e. press).
REQ-020 If pending[i] is already set when key i flips again, pol[i] SHALL take the new polarity, pending[i] SHALL stay set, and LOST SHALL set.
REQ-021 Scheduler: each cycle with FIFO count < 8, the lowest-index set pending bit SHALL be granted: push {pol[i], 3'b000, i[3:0]} and clear pending[i] in that cycle; at most one grant per cycle.
REQ-022 When the FIFO is full there SHALL be no grant; pending bits are held, not dropped.
REQ-023 FIFO: depth 8; pop when EVT_READ & EVT_VALID; EVT_READ while empty is ignored; push and pop in the same cycle SHALL keep count unchanged.
REQ-024 Latency: a grant at cycle t SHALL give EVT_VALID = 1 and the event visible at EVT_DATA (if the FIFO was empty) at cycle t+1.
REQ-025 The encoder decoder SHALL compare the previous and current synchronized {A,B} every clock.
REQ-026 Gray sequence 00->01->11->10->00 SHALL increment the count; the reverse SHALL decrement it; no change SHALL hold the count.
REQ-027 A double transition (both bits change) SHALL be ignored.
REQ-028 Encoder counts SHALL wrap modulo 256 (127+1 = -128, -128-1 = 127).
REQ-029 LOST_CLR SHALL clear LOST unless a REQ-020 overwrite happens in the same cycle; in that case LOST SHALL stay 1.

Reset
REQ-030 With EPL_RESETN = 0 at a clock edge, the block SHALL reset: KEY_STATE = 13'h1FFF, all debounce counters 0, prescaler 0, pending 0, FIFO empty, EVT_VALID 0, EVT_DATA 8'h00, IRQ_N 1, LOST 0, both counts 0, synchronizers and previous-{A,B} registers loaded with 1s.
REQ-031 Reset asserted mid-operation SHALL discard all queued and pending events; nothing is posted for that cycle.
REQ-032 A key held low through reset SHALL produce one press event after DB_SAMPLES ticks.

Verification (TICK_DIV=4, DB_SAMPLES=2)
REQ-033 KEY_IN[4] low for 3 ticks -> KEY_STATE[4] = 0 after the 2nd tick; EVT_DATA = 8'h84 one cycle after the grant; IRQ_N = 0.
REQ-034 KEY_IN[2] low for 1 tick, then high -> no event; KEY_STATE unchanged.
REQ-035 KEY_IN[0], [5] and [12] flip on the same tick -> three pops return 8'h80, 8'h85, 8'h8C in order.
REQ-036 Nine presses/releases with no EVT_READ -> count holds at 8; the 9th stays pending and is posted right after the first pop; LOST = 0.
REQ-037 ENC0 driven through 3 forward Gray steps then 5 reverse -> ENC0_COUNT = 8'hFE; a 00->11 jump leaves the count unchanged; 128 forward steps from 0 -> 8'h80.
REQ-038 Reset pulsed with 3 events queued -> EVT_VALID = 0 and IRQ_N = 1 on the next cycle, and no stale events are returned afterwards.
